uart_tx: RTL

Serial UART transmitter that consumes the one-cycle baud tick produced by the baud generator and shifts out asynchronous frames: start bit, data bits LSB first, optional parity, and one stop bit. It sits between the bus/register front end, which hands it bytes over a valid/ready handshake, and the TX pin. Every bit lasts exactly one baud-tick period. All logic runs in the single system clock domain.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types/constants; TX_PARITY state exists only with UART_TX_PARITY_EN
package uart_pkg;

    localparam int   UART_MIN_BITS = 5;
    localparam int   UART_MAX_BITS = 9;
    localparam logic UART_IDLE     = 1'b1;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_LOAD   = 3'd1,
        TX_START  = 3'd2,
        TX_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
        TX_PARITY = 3'd4,
`endif
        TX_STOP   = 3'd5
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, start + DATA_BITS (LSB first) + optional parity + stop
// Optional parity bit and parity_odd port enabled by UART_TX_PARITY_EN.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
`ifdef UART_TX_PARITY_EN
    input  logic                 parity_odd,
`endif
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx
);

    localparam int                CNT_W    = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    uart_tx_state_t       r_state, w_state_d;
    logic [DATA_BITS-1:0] r_shift, w_shift_d;
    logic [CNT_W-1:0]     r_cnt, w_cnt_d;
    logic                 r_tx, w_tx_d;
    logic                 r_ready, w_ready_d;
    logic                 w_accept;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity, w_parity_d;
`endif

    assign w_accept = tx_valid && r_ready;

    always_comb begin
        w_state_d = r_state;
        w_shift_d = r_shift;
        w_cnt_d   = r_cnt;
        w_tx_d    = r_tx;
        w_ready_d = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_d = r_parity;
`endif
        if (!en) begin
            // disable aborts any frame and drops the latched byte
            w_state_d = TX_IDLE;
            w_shift_d = '0;
            w_cnt_d   = '0;
            w_tx_d    = UART_IDLE;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    w_tx_d = UART_IDLE;
                    if (w_accept) begin
                        w_state_d = TX_LOAD;
                        w_shift_d = tx_data;
                        w_cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
                        w_parity_d = (^tx_data) ^ parity_odd;
`endif
                    end else begin
                        w_ready_d = 1'b1;
                    end
                end
                TX_LOAD: begin
                    if (baud_tick) begin
                        w_tx_d    = 1'b0;
                        w_state_d = TX_START;
                    end
                end
                TX_START: begin
                    if (baud_tick) begin
                        w_tx_d    = r_shift[0];
                        w_shift_d = r_shift >> 1;
                        w_state_d = TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (baud_tick) begin
                        if (r_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            w_tx_d    = r_parity;
                            w_state_d = TX_PARITY;
`else
                            w_tx_d    = UART_IDLE;
                            w_state_d = TX_STOP;
`endif
                        end else begin
                            w_cnt_d   = r_cnt + CNT_ONE;
                            w_tx_d    = r_shift[0];
                            w_shift_d = r_shift >> 1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                TX_PARITY: begin
                    if (baud_tick) begin
                        w_tx_d    = UART_IDLE;
                        w_state_d = TX_STOP;
                    end
                end
`endif
                TX_STOP: begin
                    if (baud_tick) begin
                        w_state_d = TX_IDLE;
                    end
                end
                default: begin
                    w_state_d = TX_IDLE;
                    w_tx_d    = UART_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= TX_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_tx    <= UART_IDLE;
            r_ready <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state <= w_state_d;
            r_shift <= w_shift_d;
            r_cnt   <= w_cnt_d;
            r_tx    <= w_tx_d;
            r_ready <= w_ready_d;
`ifdef UART_TX_PARITY_EN
            r_parity <= w_parity_d;
`endif
        end
    end

    assign tx       = r_tx;
    assign tx_ready = r_ready;
    assign tx_busy  = (r_state != TX_IDLE);

endmodule
